// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the batch executor.
package instr_register_pkg;

    localparam int unsigned OPERAND_W = 32;
    localparam int unsigned RESULT_W  = 64;
    localparam int unsigned PTR_W     = 5;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [OPERAND_W-1:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [RESULT_W-1:0] result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational evaluator: sign-extends both operands to 64 bits and applies the opcode.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      res,
    output logic         div_zero
);

    result_t a;
    result_t b;

    always_comb begin
        a        = {{(RESULT_W-OPERAND_W){instr.op_a[OPERAND_W-1]}}, instr.op_a};
        b        = {{(RESULT_W-OPERAND_W){instr.op_b[OPERAND_W-1]}}, instr.op_b};
        res      = '0;
        div_zero = 1'b0;
        case (instr.opc)
            ZERO:  res = '0;
            PASSA: res = a;
            PASSB: res = b;
            ADD:   res = a + b;
            SUB:   res = a - b;
            MULT:  res = a * b;
            // Signed / and % truncate toward zero; remainder follows the dividend.
            DIV:   if (b == '0) div_zero = 1'b1; else res = a / b;
            MOD:   if (b == '0) div_zero = 1'b1; else res = a % b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/instr_executor.sv
// Batch executor: fetches count instructions from consecutive register locations,
// evaluates each one and hands the result out over a valid/ready port.
module instr_executor
    import instr_register_pkg::*;
#(
    parameter int unsigned REG_DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [PTR_W-1:0]   first_ptr,
    input  logic [CNT_W-1:0]   count,
    output logic [PTR_W-1:0]   read_pointer,
    input  instruction_t       instruction_word,
    output logic               result_valid,
    input  logic               result_ready,
    output result_t            result,
    output opcode_t            result_opc,
    output logic [PTR_W-1:0]   result_ptr,
    output logic               div_zero_err,
    output logic               busy,
    output logic               done
);

    exec_state_t        state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    instruction_t       word_q, word_d;
    result_t            res_q, res_d;
    opcode_t            opc_q, opc_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic               dz_q, dz_d;
    logic               valid_q, busy_q, done_q;

    result_t            alu_res;
    logic               alu_dz;

    instr_alu u_alu (
        .instr    (word_q),
        .res      (alu_res),
        .div_zero (alu_dz)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        res_d   = res_q;
        opc_d   = opc_q;
        rptr_d  = rptr_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        ptr_d   = first_ptr;
                        cnt_d   = count;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                word_d  = instruction_word;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_res;
                opc_d   = word_q.opc;
                rptr_d  = ptr_q;
                dz_d    = alu_dz;
                state_d = RESP;
            end
            RESP: begin
                if (result_ready) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    ptr_d   = (ptr_q == PTR_W'(REG_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            res_q   <= '0;
            opc_q   <= ZERO;
            rptr_q  <= '0;
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            res_q   <= res_d;
            opc_q   <= opc_d;
            rptr_q  <= rptr_d;
            dz_q    <= dz_d;
            valid_q <= (state_d == RESP);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign read_pointer = ptr_q;
    assign result_valid = valid_q;
    assign result       = res_q;
    assign result_opc   = opc_q;
    assign result_ptr   = rptr_q;
    assign div_zero_err = dz_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_instr_executor.sv
// Self-checking bench for instr_executor: vector table plus scoreboard of expected results.
module tb_instr_executor;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [4:0]   first_ptr;
    logic [5:0]   count;
    logic [4:0]   read_pointer;
    instruction_t instruction_word;
    logic         result_valid;
    logic         result_ready;
    result_t      result;
    opcode_t      result_opc;
    logic [4:0]   result_ptr;
    logic         div_zero_err;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    instr_executor #(.REG_DEPTH(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_ptr        (first_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result           (result),
        .result_opc       (result_opc),
        .result_ptr       (result_ptr),
        .div_zero_err     (div_zero_err),
        .busy             (busy),
        .done             (done)
    );

    typedef struct {
        logic [3:0]          opc;
        logic signed [31:0]  a;
        logic signed [31:0]  b;
        logic signed [63:0]  res;
        logic                dz;
    } vec_t;

    typedef struct {
        logic signed [63:0]  res;
        logic [3:0]          opc;
        logic [4:0]          ptr;
        logic                dz;
    } exp_t;

    vec_t         vt [17];
    exp_t         sb [$];
    int           hs_cyc [$];
    instruction_t mem [32];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int done_cnt = 0;

    assign instruction_word = mem[read_pointer];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a handshake is committed at the following rising edge.
    always @(negedge clk) begin
        if (result_valid) valid_cnt++;
        if (done) done_cnt++;
        if (reset_n && result_valid && result_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got result %0h with no expected entry", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("result_opc", 64'(result_opc), 64'(e.opc));
                check("result_ptr", 64'(result_ptr), 64'(e.ptr));
                check("div_zero_err", 64'(div_zero_err), 64'(e.dz));
            end
        end
    end

    task automatic load(input int first, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            int p;
            exp_t e;
            p = (first + i) % 32;
            mem[p] = '{opcode_t'(vt[base+i].opc), vt[base+i].a, vt[base+i].b};
            e.res = vt[base+i].res;
            e.opc = vt[base+i].opc;
            e.ptr = 5'(p);
            e.dz  = vt[base+i].dz;
            sb.push_back(e);
        end
    endtask

    task automatic start_pulse(input int fp, input int c);
        @(posedge clk);
        #1;
        start     = 1'b1;
        first_ptr = 5'(fp);
        count     = 6'(c);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, v0, d0;

        vt[0]  = '{ADD,   5,   3,   8,   1'b0};
        vt[1]  = '{SUB,  -4,   7, -11,   1'b0};
        vt[2]  = '{MULT, -15, 15, -225,  1'b0};
        vt[3]  = '{DIV,  -15,  4,  -3,   1'b0};
        vt[4]  = '{MOD,  -15,  4,  -3,   1'b0};
        vt[5]  = '{DIV,    7,  0,   0,   1'b1};
        vt[6]  = '{MOD,   -9,  0,   0,   1'b1};
        vt[7]  = '{ZERO, 123, 456,  0,   1'b0};
        vt[8]  = '{PASSA, -1,  9,  -1,   1'b0};
        vt[9]  = '{PASSB,  1, 32'sh80000000, -64'sd2147483648, 1'b0};
        vt[10] = '{MULT, 32'sh7fffffff, 32'sh7fffffff, 64'sh3fffffff00000001, 1'b0};
        vt[11] = '{DIV,   -7, -2,   3,   1'b0};
        vt[12] = '{MOD,    7, -2,   1,   1'b0};
        vt[13] = '{4'hF,   3,  4,   0,   1'b0};
        vt[14] = '{SUB, 32'sh80000000, 1, -64'sd2147483649, 1'b0};
        vt[15] = '{ADD,   10, 20,  30,   1'b0};
        vt[16] = '{MULT,  -3, -7,  21,   1'b0};

        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset_n      = 1'b0;
        start        = 1'b0;
        first_ptr    = '0;
        count        = '0;
        result_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rdptr", 64'(read_pointer), 64'd0);
        check("rst_opc", 64'(result_opc), 64'(ZERO));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic three-instruction batch: latency, throughput, single done.
        load(0, 3, 0);
        hs_cyc.delete();
        d0 = done_cnt;
        start_pulse(0, 3);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid) break;
            @(posedge clk);
            lat++;
        end
        check("first_latency", 64'(lat), 64'd3);
        wait_done("done_basic");
        check("done_once_basic", 64'(done_cnt - d0), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("sb_empty_basic", 64'(sb.size()), 64'd0);
        if (hs_cyc.size() == 3) begin
            check("throughput_0", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
            check("throughput_1", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
        end else begin
            check("handshake_count", 64'(hs_cyc.size()), 64'd3);
        end

        // Rest of the opcode table, including divide-by-zero and out-of-enum opcode.
        load(3, 12, 3);
        start_pulse(3, 12);
        wait_done("done_table");
        check("sb_empty_table", 64'(sb.size()), 64'd0);

        // Pointer wraps from 31 to 0.
        load(31, 2, 15);
        start_pulse(31, 2);
        wait_done("done_wrap");
        check("sb_empty_wrap", 64'(sb.size()), 64'd0);

        // Backpressure: fields hold and a start while busy is ignored.
        result_ready = 1'b0;
        load(5, 1, 16);
        start_pulse(5, 1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid) break;
            lat++;
        end
        check("stall_valid_seen", 64'(result_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            start     = (i == 2);
            first_ptr = 5'd20;
            count     = 6'd3;
            @(negedge clk);
            check("stall_result", result, 64'sd21);
            check("stall_ptr", 64'(result_ptr), 64'd5);
            check("stall_rdptr", 64'(read_pointer), 64'd5);
            check("stall_valid", 64'(result_valid), 64'd1);
            check("stall_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        start        = 1'b0;
        result_ready = 1'b1;
        wait_done("done_stall");
        check("sb_empty_stall", 64'(sb.size()), 64'd0);
        v0 = valid_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("ignored_start_valid", 64'(valid_cnt - v0), 64'd0);
        check("ignored_start_busy", 64'(busy), 64'd0);

        // Asynchronous reset while in EXEC.
        load(10, 3, 0);
        start_pulse(10, 3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", 64'(result_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_rdptr", 64'(read_pointer), 64'd0);
        check("mid_rst_result", result, 64'd0);
        check("mid_rst_rptr", 64'(result_ptr), 64'd0);
        check("mid_rst_dz", 64'(div_zero_err), 64'd0);
        check("mid_rst_opc", 64'(result_opc), 64'(ZERO));
        v0 = valid_cnt;
        d0 = done_cnt;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_valid", 64'(valid_cnt - v0), 64'd0);
        check("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Zero-length batch.
        v0 = valid_cnt;
        d0 = done_cnt;
        start_pulse(0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("zero_cnt_done", 64'(done_cnt - d0), 64'd1);
        check("zero_cnt_no_valid", 64'(valid_cnt - v0), 64'd0);
        check("zero_cnt_busy", 64'(busy), 64'd0);
        check("sb_empty_final", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_executor.md
INSTR_EXECUTOR -- requirements
Module: instr_executor

Interface
REQ-001 The block SHALL have parameter REG_DEPTH, default 32, giving the number of instruction-register locations addressable by read_pointer.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to execute a batch of instructions.
REQ-005 The block SHALL have port first_ptr, input, 5 bits, the first register location of the batch, sampled with start.
REQ-006 The block SHALL have port count, input, 6 bits, the number of instructions in the batch (0..32), sampled with start.
REQ-007 The block SHALL have port read_pointer, output, 5 bits, the address driven to the instruction register.
REQ-008 The block SHALL have port instruction_word, input, instruction_t {opc, op_a, op_b}, the combinational read data at read_pointer.
REQ-009 The block SHALL have port result_valid, output, 1 bit, indicating the result fields hold valid data.
REQ-010 The block SHALL have port result_ready, input, 1 bit, the consumer's acceptance of a result.
REQ-011 The block SHALL have port result, output, 64 bits signed, the executed value.
REQ-012 The block SHALL have port result_opc, output, opcode_t, the opcode that produced result.
REQ-013 The block SHALL have port result_ptr, output, 5 bits, the location that produced result.
REQ-014 The block SHALL have port div_zero_err, output, 1 bit, set alongside a DIV or MOD result whose op_b = 0.
REQ-015 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1 bit, a one-cycle pulse at batch end.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, EXEC, RESP and DONE.
REQ-018 In IDLE, start = 1 with count > 0 SHALL latch first_ptr and count, load the pointer, and go to FETCH.
REQ-019 In IDLE, start = 1 with count = 0 SHALL go directly to DONE and emit no results.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 In FETCH, read_pointer SHALL equal the current pointer, and instruction_word SHALL be captured into an internal register at the end of the cycle; the next state SHALL be EXEC.
REQ-022 In EXEC, the captured word SHALL be evaluated and result, result_opc, result_ptr and div_zero_err SHALL be registered; the next state SHALL be RESP.
REQ-023 In RESP, result_valid SHALL be 1, and all result fields SHALL be held stable until result_valid = 1 and result_ready = 1 in the same cycle.
REQ-024 On the RESP handshake, the remaining count SHALL be decremented and the pointer incremented modulo 32 (31 wraps to 0).
REQ-025 On the RESP handshake, the next state SHALL be FETCH if instructions remain, otherwise DONE.
REQ-026 Latency from start to the first result_valid SHALL be 3 cycles.
REQ-027 With result_ready held at 1, throughput SHALL be one result every 3 cycles.
REQ-028 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-029 Arithmetic SHALL sign-extend op_a and op_b (signed 32-bit) to 64 bits before evaluation.
REQ-030 ZERO SHALL produce 0, PASSA op_a, PASSB op_b, ADD a+b, SUB a-b and MULT the full 64-bit product.
REQ-031 DIV SHALL truncate toward zero, and MOD SHALL take the sign of the dividend.
REQ-032 DIV or MOD with op_b = 0 SHALL produce result 0 with div_zero_err = 1; otherwise div_zero_err SHALL be 0.
REQ-033 An opcode value outside the enum SHALL produce 0 with div_zero_err = 0.

Reset
REQ-034 When reset_n = 0, the FSM SHALL go to IDLE immediately, regardless of clk, including mid-batch.
REQ-035 When reset_n = 0, read_pointer, result, result_ptr, the count and the pointer SHALL clear to 0.
REQ-036 When reset_n = 0, result_valid, busy, done and div_zero_err SHALL clear to 0, and result_opc SHALL clear to ZERO.
REQ-037 After reset_n is released, no result or done SHALL be produced until a new start.

Structure
REQ-038 The shared package instr_register_pkg SHALL hold opcode_t, operand_t, instruction_t, a new result_t (signed 64-bit) and a new exec_state_t enum.
REQ-039 The arithmetic SHALL be a combinational sub-module instr_alu (inputs instruction_t; outputs result_t and the div-zero flag), instantiated once.

Verification
REQ-040 Reset then start, first_ptr = 0, count = 3, with locations {ADD 5,3}, {SUB -4,7}, {MULT -15,15} and result_ready = 1 -> results 8, -11, -225 with result_ptr 0, 1, 2; first result_valid 3 cycles after start; done pulses once.
REQ-041 count = 2, first_ptr = 31 -> results from locations 31 then 0 (wrap-around).
REQ-042 DIV -15,4 -> -3; MOD -15,4 -> -3; DIV 7,0 -> result 0 with div_zero_err = 1.
REQ-043 result_ready held low for 5 cycles in RESP -> all result fields stable; no further read_pointer change; start pulsed while busy is ignored.
REQ-044 reset_n asserted mid-batch while in EXEC -> all outputs 0 immediately; no done after release.
REQ-045 start with count = 0 -> done pulses and no result_valid is produced.
